// File: rtl/mult_pkg.sv
// mult_pkg
// Shared definitions for the shift_add_mult Booth multiplier:
//   - state_t     : controller states (IDLE, RUN, DONE)
//   - WIDTH       : operand / result width (only 32 is supported)
//   - STEP_COUNT  : number of Booth iterations per multiply
//   - PROD_W      : width of the {upper, lower, q-1} product register
//   - product_overflow() : signed-overflow test on a full-width product
package mult_pkg;

    localparam int WIDTH  = 32;
    localparam int CNT_W  = 6;
    localparam int PROD_W = 2 * WIDTH + 1;

    localparam logic [CNT_W-1:0] STEP_COUNT = 6'd32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The product fits in WIDTH signed bits only when every upper bit is a
    // copy of the sign bit of the lower word.
    function automatic logic product_overflow(input logic [2*WIDTH-1:0] product);
        return product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}};
    endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step
// One combinational radix-2 Booth iteration on the product register.
// Ports:
//   prod_in  [PROD_W-1:0] : {upper, lower, q-1} before the step
//   mcand    [WIDTH-1:0]  : signed multiplicand
//   prod_out [PROD_W-1:0] : {upper, lower, q-1} after add/sub/skip and shift
module booth_step
    import mult_pkg::*;
(
    input  logic [PROD_W-1:0] prod_in,
    input  logic [WIDTH-1:0]  mcand,
    output logic [PROD_W-1:0] prod_out
);

    logic [WIDTH:0] upper_ext;
    logic [WIDTH:0] mcand_ext;
    logic [WIDTH:0] sum;

    // The add/subtract is done one bit wider than the upper word so that
    // subtracting the most negative multiplicand cannot corrupt the sign.
    // The extra sum bit becomes the bit shifted into the top, which makes the
    // shift arithmetic; any carry beyond 33 bits is simply dropped.
    always_comb begin
        upper_ext = {prod_in[PROD_W-1], prod_in[PROD_W-1:WIDTH+1]};
        mcand_ext = {mcand[WIDTH-1], mcand};
        case (prod_in[1:0])
            2'b01:   sum = upper_ext + mcand_ext;
            2'b10:   sum = upper_ext - mcand_ext;
            default: sum = upper_ext;
        endcase
        prod_out = {sum, prod_in[WIDTH:1]};
    end

endmodule

// File: rtl/shift_add_mult.sv
// shift_add_mult
// Sequential radix-2 Booth signed multiplier, one Booth step per clock.
// A start pulse latches both operands; 33 cycles later a one-cycle done pulse
// is given together with the low word of the product and an overflow flag.
// Starting again while running aborts the current operation.
// Ports:
//   clock          : rising-edge clock
//   reset          : asynchronous active-high reset
//   ctrl_MULT      : start / restart pulse, operands sampled on its edge
//   data_operandA  : signed multiplicand
//   data_operandB  : signed multiplier
//   data_result    : low WIDTH bits of the signed product (held)
//   data_exception : signed overflow of the WIDTH-bit result (held)
//   data_resultRDY : one-cycle done pulse
//   busy           : high while in RUN
// Configuration:
//   SHIFT_ADD_MULT_ZERO_SKIP_EN : when defined, a zero operand finishes one
//   cycle after the start edge with result 0 and no exception.
module shift_add_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    import mult_pkg::*;

    localparam int PW = 2 * WIDTH + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exception_q, exception_d;
    logic             rdy_q, rdy_d;
    logic [PW-1:0]    prod_step;

    booth_step u_booth_step (
        .prod_in  (prod_q),
        .mcand    (mcand_q),
        .prod_out (prod_step)
    );

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            prod_q      <= '0;
            mcand_q     <= '0;
            result_q    <= '0;
            exception_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            prod_q      <= prod_d;
            mcand_q     <= mcand_d;
            result_q    <= result_d;
            exception_q <= exception_d;
            rdy_q       <= rdy_d;
        end
    end

    // Controller. A start in any state latches the operands and restarts the
    // step counter, which is also how an in-flight operation gets aborted.
    // In RUN the counter sits at 0..31 while steps are applied; at 32 all
    // steps are done and the result is published on the transition to DONE.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        prod_d      = prod_q;
        mcand_d     = mcand_q;
        result_d    = result_q;
        exception_d = exception_q;
        rdy_d       = 1'b0;

        if (ctrl_MULT) begin
            state_d = RUN;
            count_d = '0;
            mcand_d = data_operandA;
            prod_d  = {{WIDTH{1'b0}}, data_operandB, 1'b0};
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
`ifdef SHIFT_ADD_MULT_ZERO_SKIP_EN
                    if (count_q == '0 && (mcand_q == '0 || prod_q[WIDTH:1] == '0)) begin
                        state_d     = DONE;
                        rdy_d       = 1'b1;
                        result_d    = '0;
                        exception_d = 1'b0;
                    end else
`endif
                    if (count_q == STEP_COUNT) begin
                        state_d     = DONE;
                        rdy_d       = 1'b1;
                        result_d    = prod_q[WIDTH:1];
                        exception_d = product_overflow(prod_q[PW-1:1]);
                    end else begin
                        prod_d  = prod_step;
                        count_d = count_q + 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_exception = exception_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q == RUN);

endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult
// Self-checking bench for shift_add_mult. Expected products come from plain
// 64-bit signed arithmetic; latency and busy expectations come from the
// start-edge / done-pulse timing of the multiplier.
// Honours SHIFT_ADD_MULT_ZERO_SKIP_EN when compiled with it.
module tb_shift_add_mult;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int check_count = 0;
    int fail_count  = 0;

    shift_add_mult #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Reference: full signed product via ordinary 64-bit multiplication.
    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
    endfunction

    function automatic logic ref_overflow(input logic [63:0] p);
        longint low_ext;
        low_ext = longint'($signed(p[31:0]));
        return (64'(low_ext) != p);
    endfunction

    // Cycles from the start edge to the done pulse.
    function automatic int expected_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef SHIFT_ADD_MULT_ZERO_SKIP_EN
        if (a == 32'd0 || b == 32'd0) return 1;
`endif
        return 33;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge: drive the start, let the start edge pass,
    // then drop ctrl_MULT and scramble the operands to prove they were latched.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Start one multiply and watch 40 cycles for the done pulse, busy window,
    // result, exception and hold behaviour.
    task automatic run_and_check(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] prod;
        int          lat;
        int          rdy_seen;
        int          rdy_cycle;
        int          busy_bad;
        logic [31:0] res_at_rdy;
        logic        exc_at_rdy;
        prod       = ref_product(a, b);
        lat        = expected_latency(a, b);
        rdy_seen   = 0;
        rdy_cycle  = -1;
        busy_bad   = 0;
        res_at_rdy = '0;
        exc_at_rdy = 1'b0;
        apply_stimulus(a, b);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                rdy_seen++;
                if (rdy_cycle < 0) begin
                    rdy_cycle  = cyc;
                    res_at_rdy = data_result;
                    exc_at_rdy = data_exception;
                end
            end
            if (busy !== (cyc < lat)) busy_bad++;
        end
        check_output({tag, " rdy_cycle"}, 64'(rdy_cycle), 64'(lat));
        check_output({tag, " rdy_pulses"}, 64'(rdy_seen), 64'd1);
        check_output({tag, " result"}, 64'(res_at_rdy), 64'(prod[31:0]));
        check_output({tag, " exception"}, 64'(exc_at_rdy), 64'(ref_overflow(prod)));
        check_output({tag, " busy_window_errors"}, 64'(busy_bad), 64'd0);
        check_output({tag, " result_held"}, 64'(data_result), 64'(prod[31:0]));
    endtask

    initial begin
        int early_rdy;
        int late_rdy;
        int late_busy;
        logic [31:0] ra;
        logic [31:0] rb;

        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(negedge clock);
        check_output("reset result", 64'(data_result), 64'd0);
        check_output("reset exception", 64'(data_exception), 64'd0);
        check_output("reset rdy", 64'(data_resultRDY), 64'd0);
        check_output("reset busy", 64'(busy), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        run_and_check(32'd3, 32'd4, "3x4");
        run_and_check(32'hFFFF_FFF9, 32'd6, "-7x6");

        // Reset in the middle of an operation, with a nonzero held result.
        apply_stimulus(32'd5, 32'd5);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        #1;
        check_output("midreset result", 64'(data_result), 64'd0);
        check_output("midreset exception", 64'(data_exception), 64'd0);
        check_output("midreset rdy", 64'(data_resultRDY), 64'd0);
        check_output("midreset busy", 64'(busy), 64'd0);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd7;
        data_operandB = 32'd7;
        repeat (2) @(negedge clock);
        ctrl_MULT = 1'b0;
        reset     = 1'b0;
        late_rdy  = 0;
        late_busy = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) late_rdy++;
            if (busy !== 1'b0) late_busy++;
        end
        check_output("after reset rdy pulses", 64'(late_rdy), 64'd0);
        check_output("after reset busy cycles", 64'(late_busy), 64'd0);

        run_and_check(32'h0001_0000, 32'h0001_0000, "2^16x2^16");
        run_and_check(32'h8000_0000, 32'hFFFF_FFFF, "minx-1");
        run_and_check(32'h8000_0000, 32'h8000_0000, "minxmin");
        run_and_check(32'd0, 32'd123, "0x123");
        run_and_check(32'd77, 32'd0, "77x0");

        // Abort: 5x5 restarted as 2x9 on the tenth edge after the start.
        apply_stimulus(32'd5, 32'd5);
        early_rdy = 0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) early_rdy++;
        end
        run_and_check(32'd2, 32'd9, "abort 2x9");
        check_output("abort early rdy", 64'(early_rdy), 64'd0);

        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                ra = $urandom;
                rb = $urandom;
            end else begin
                ra = 32'($urandom_range(0, 2000)) - 32'd1000;
                rb = 32'($urandom_range(0, 2000)) - 32'd1000;
            end
            $display("[TB] random op %0d: A=0x%08h B=0x%08h", i, ra, rb);
            run_and_check(ra, rb, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
